// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over imem req/ack and
// hands each instruction to decode over valid/ready, honouring redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend, pend_nxt;
    logic [31:0] instr_nxt, instr_pc_nxt, pc_plus4_nxt;
    logic        valid_nxt;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = redirect_pc & ~32'h0000_0003;
    assign pc_inc = pc + 32'd4;

    // Gated by rst_n so an in-flight request is dropped the instant reset asserts.
    assign imem_req  = rst_n & (state != HOLD);
    assign imem_addr = pc;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pend_nxt     = pend;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;
        pc_plus4_nxt = pc_plus4;
        valid_nxt    = instr_valid;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        pc_nxt = target;
                    end else begin
                        // Request already issued: must drain it before retargeting.
                        pend_nxt  = target;
                        state_nxt = DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_nxt    = imem_rdata;
                    instr_pc_nxt = pc;
                    pc_plus4_nxt = pc_inc;
                    pc_nxt       = pc_inc;
                    valid_nxt    = 1'b1;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end else if (instr_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    pc_nxt    = redirect_valid ? target : pend;
                    state_nxt = FETCH;
                end else if (redirect_valid) begin
                    pend_nxt = target;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pend        <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            pc_plus4    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend        <= pend_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            pc_plus4    <= pc_plus4_nxt;
            instr_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a simple programmable-latency
// instruction memory returning addr ^ 32'hA5A5_0000.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    // memory model: ack once the request has waited lat cycles
    int   lat    = 0;
    int   wcnt   = 0;
    logic mem_en = 1'b0;

    assign imem_ack   = mem_en && imem_req && (wcnt == lat);
    assign imem_rdata = imem_ack ? (imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_p4;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int max);
        int n = 0;
        while (!instr_valid && n < max) begin
            tick();
            n++;
        end
        chk({name, "_valid_timeout"}, {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_2003, 1'b1, 32'h0000_2000, 32'hA5A5_2000, 32'h0000_2004};
        vecs[1] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h0000_0001, 1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'h0000_0004};
        vecs[3] = '{32'h1234_5678, 1'b0, 32'h1234_5678, 32'hB791_5678, 32'h1234_567C};
        vecs[4] = '{32'h8000_0006, 1'b1, 32'h8000_0004, 32'h25A5_0004, 32'h8000_0008};

        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // reset state
        #3;
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr,    32'd0);
        chk("rst_ipc",   instr_pc, 32'd0);
        chk("rst_p4",    pc_plus4, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_req",   {31'd0, imem_req},    32'd1);
        chk("first_addr",  imem_addr,            32'h0040_0000);
        chk("first_valid", {31'd0, instr_valid}, 32'd0);
        mem_en      = 1'b1;
        instr_ready = 1'b1;

        // zero-wait streaming: one instruction every other cycle
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stream_valid", {31'd0, instr_valid}, 32'd1);
            chk("stream_ipc",   instr_pc, 32'h0040_0000 + 32'(4 * k));
            chk("stream_instr", instr,    32'hA5E5_0000 + 32'(4 * k));
            chk("stream_p4",    pc_plus4, 32'h0040_0004 + 32'(4 * k));
            tick();
            chk("stream_gap", {31'd0, instr_valid}, 32'd0);
        end

        // decode stall in HOLD
        instr_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_req",   {31'd0, imem_req},    32'd0);
            chk("hold_ipc",   instr_pc, 32'h0040_000C);
            chk("hold_instr", instr,    32'hA5E5_000C);
            chk("hold_p4",    pc_plus4, 32'h0040_0010);
        end
        instr_ready = 1'b1;
        tick();
        chk("after_hold_req",  {31'd0, imem_req}, 32'd1);
        chk("after_hold_addr", imem_addr, 32'h0040_0010);

        // slow memory, redirect while a request is outstanding
        lat            = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drain_valid", {31'd0, instr_valid}, 32'd0);
            chk("drain_addr",  imem_addr, 32'h0040_0010);
            chk("drain_req",   {31'd0, imem_req}, 32'd1);
            tick();
        end
        chk("post_drain_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_drain_addr",  imem_addr, 32'h0000_1000);
        wait_valid("slow", 10);
        chk("slow_ipc",   instr_pc, 32'h0000_1000);
        chk("slow_instr", instr,    32'hA5A5_1000);
        lat = 0;

        // redirects from HOLD, with and without ready; masked target and wrap
        foreach (vecs[i]) begin
            wait_valid("vec_pre", 10);
            instr_ready    = vecs[i].rdy;
            redirect_valid = 1'b1;
            redirect_pc    = vecs[i].rpc;
            tick();
            redirect_valid = 1'b0;
            instr_ready    = 1'b1;
            chk("vec_squash", {31'd0, instr_valid}, 32'd0);
            chk("vec_addr",   imem_addr, vecs[i].exp_addr);
            tick();
            chk("vec_valid", {31'd0, instr_valid}, 32'd1);
            chk("vec_ipc",   instr_pc, vecs[i].exp_addr);
            chk("vec_instr", instr,    vecs[i].exp_instr);
            chk("vec_p4",    pc_plus4, vecs[i].exp_p4);
            tick();
            wait_valid("vec_next", 10);
            chk("vec_next_ipc", instr_pc, vecs[i].exp_p4);
        end

        // redirect in FETCH with a same-cycle ack: response dropped
        tick();
        chk("fack_state_req", {31'd0, imem_req}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick();
        redirect_valid = 1'b0;
        chk("fack_valid", {31'd0, instr_valid}, 32'd0);
        chk("fack_addr",  imem_addr, 32'h0000_3000);
        tick();
        chk("fack_ipc", instr_pc, 32'h0000_3000);

        // async reset in the middle of a waited request
        lat = 3;
        tick();
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'd0, imem_req},    32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instr", instr, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
